// File: rtl/updown_pkg.sv
// Shared encodings for the up/down counter monitor: FSM states, step classes
// and the direction-correctness rule.
package updown_pkg;

   localparam logic [1:0] ST_SYNC    = 2'd0;
   localparam logic [1:0] ST_ACQUIRE = 2'd1;
   localparam logic [1:0] ST_LOCKED  = 2'd2;

   typedef enum logic [1:0] {
      STEP_UP   = 2'd0,
      STEP_DOWN = 2'd1,
      STEP_HOLD = 2'd2,
      STEP_JUMP = 2'd3
   } step_class_e;

   // A step is correct only when it moves one unit in the expected direction.
   function automatic logic is_correct(input step_class_e cls, input logic up_exp);
      return ((cls == STEP_UP) && up_exp) || ((cls == STEP_DOWN) && !up_exp);
   endfunction

endpackage

// File: rtl/updown_count_monitor_step_classifier.sv
// Combinational classifier of one counter step from the modular difference
// between the current and previous count values.
module step_classifier
   import updown_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] prev_i,
   input  logic [WIDTH-1:0] count_i,
   output step_class_e      class_o
);

   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

   logic [WIDTH-1:0] delta_s;

   assign delta_s = count_i - prev_i;

   // Map the modular delta onto the four step classes.
   always_comb begin
      class_o = STEP_JUMP;
      if (delta_s == ONE) begin
         class_o = STEP_UP;
      end else if (delta_s == ONES) begin
         class_o = STEP_DOWN;
      end else if (delta_s == ZERO) begin
         class_o = STEP_HOLD;
      end else begin
         class_o = STEP_JUMP;
      end
   end

endmodule

// File: rtl/updown_count_monitor.sv
// Monitors an observed up/down counter against its commanded direction,
// locking after LOCK_N correct steps and flagging errors and wraps while locked.
module updown_count_monitor
   import updown_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int LOCK_N = 2,
   parameter int ERRW   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             up,
   input  logic [WIDTH-1:0] count,
   output logic             locked,
   output logic             dir,
   output logic             err,
   output logic             wrap,
   output logic [ERRW-1:0]  err_count
);

   localparam int RUNW = $clog2(LOCK_N + 1);
   localparam logic [RUNW-1:0]  RUN_ONE  = RUNW'(1);
   localparam logic [RUNW-1:0]  RUN_LAST = RUNW'(LOCK_N - 1);
   localparam logic [RUNW-1:0]  RUN_ZERO = RUNW'(0);
   localparam logic [WIDTH-1:0] CNT_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
   localparam logic [ERRW-1:0]  ERR_MAX  = {ERRW{1'b1}};
   localparam logic [ERRW-1:0]  ERR_ONE  = ERRW'(1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] prev_q;
   logic             up_q;
   logic [RUNW-1:0]  run_q, run_d;
   logic             locked_q, dir_q, dir_d, err_q, err_d, wrap_q, wrap_d;
   logic [ERRW-1:0]  err_count_q, err_count_d;
   step_class_e      class_s;
   logic             correct_s, wrap_s;

   step_classifier #(.WIDTH(WIDTH)) u_classifier (
      .prev_i  (prev_q),
      .count_i (count),
      .class_o (class_s)
   );

   // The observed counter reacts one edge late, so up_q is the expectation.
   assign correct_s = is_correct(class_s, up_q);
   assign wrap_s    = ((class_s == STEP_UP)   && (prev_q == CNT_ONES) && (count == CNT_ZERO)) ||
                      ((class_s == STEP_DOWN) && (prev_q == CNT_ZERO) && (count == CNT_ONES));

   // Next-state logic for the lock FSM, run length, pulses and error total.
   always_comb begin
      state_d     = state_q;
      run_d       = run_q;
      dir_d       = dir_q;
      err_d       = 1'b0;
      wrap_d      = 1'b0;
      err_count_d = err_count_q;
      case (state_q)
         ST_SYNC: begin
            state_d = ST_ACQUIRE;
            run_d   = RUN_ZERO;
         end
         ST_ACQUIRE: begin
            if (correct_s && (run_q == RUN_LAST)) begin
               state_d = ST_LOCKED;
               run_d   = RUN_ZERO;
            end else if (correct_s) begin
               run_d = run_q + RUN_ONE;
            end else begin
               run_d = RUN_ZERO;
            end
         end
         ST_LOCKED: begin
            if (correct_s) begin
               wrap_d = wrap_s;
            end else begin
               err_d   = 1'b1;
               state_d = ST_ACQUIRE;
               run_d   = RUN_ZERO;
               if (err_count_q != ERR_MAX) begin
                  err_count_d = err_count_q + ERR_ONE;
               end else begin
                  err_count_d = err_count_q;
               end
            end
         end
         default: begin
            state_d = ST_SYNC;
            run_d   = RUN_ZERO;
         end
      endcase
      // The SYNC sample has no valid predecessor, so it never moves dir.
      if ((state_q != ST_SYNC) && (class_s == STEP_UP)) begin
         dir_d = 1'b1;
      end else if ((state_q != ST_SYNC) && (class_s == STEP_DOWN)) begin
         dir_d = 1'b0;
      end else begin
         dir_d = dir_q;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_SYNC;
         prev_q      <= CNT_ZERO;
         up_q        <= 1'b0;
         run_q       <= RUN_ZERO;
         locked_q    <= 1'b0;
         dir_q       <= 1'b0;
         err_q       <= 1'b0;
         wrap_q      <= 1'b0;
         err_count_q <= {ERRW{1'b0}};
      end else begin
         state_q     <= state_d;
         prev_q      <= count;
         up_q        <= up;
         run_q       <= run_d;
         locked_q    <= (state_d == ST_LOCKED);
         dir_q       <= dir_d;
         err_q       <= err_d;
         wrap_q      <= wrap_d;
         err_count_q <= err_count_d;
      end
   end

   assign locked    = locked_q;
   assign dir       = dir_q;
   assign err       = err_q;
   assign wrap      = wrap_q;
   assign err_count = err_count_q;

endmodule

// File: doc/updown_count_monitor.md
UPDOWN_COUNT_MONITOR -- requirements
Module: updown_count_monitor

Interface
REQ-001 Parameter WIDTH, default 4, width of the observed count bus.
REQ-002 Parameter LOCK_N, default 2, number of consecutive correct steps needed to assert lock.
REQ-003 Parameter ERRW, default 8, width of the error counter.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port up  input  1  commanded direction of the observed counter (1 = up, 0 = down).
REQ-007 Port count  input  WIDTH  observed counter output.
REQ-008 Port locked  output  1  high while the count stream tracks the commanded direction.
REQ-009 Port dir  output  1  direction of the last valid unit step (1 = up).
REQ-010 Port err  output  1  one-cycle pulse on a tracking error while locked.
REQ-011 Port wrap  output  1  one-cycle pulse on a correct wrap step while locked.
REQ-012 Port err_count  output  ERRW  saturating total of err pulses since reset.

Function
REQ-013 The monitor SHALL register count into prev_q and up into up_q on every edge.
REQ-014 The step classification SHALL use delta = (count - prev_q) mod 2^WIDTH:
- delta 1 is UP.
- delta all-ones is DOWN.
- delta 0 is HOLD.
- Any other delta is JUMP.
REQ-015 The expected direction SHALL be up_q, because the observed counter reacts one edge after up changes.
REQ-016 A CORRECT step SHALL be UP with up_q=1 or DOWN with up_q=0; any other class SHALL be BAD.
REQ-017 The FSM SHALL have the states SYNC, ACQUIRE and LOCKED.
REQ-018 In SYNC, the FSM SHALL only capture prev_q and up_q, then go to ACQUIRE with run=0.
REQ-019 In ACQUIRE:
- CORRECT increments run.
- BAD clears run.
- When run reaches LOCK_N, the FSM goes to LOCKED and run clears.
REQ-020 In LOCKED:
- CORRECT keeps LOCKED.
- BAD (including HOLD) pulses err for one cycle, increments err_count and goes to ACQUIRE with run=0.
REQ-021 locked SHALL equal (state == LOCKED) and SHALL be registered.
REQ-022 wrap SHALL pulse on a CORRECT step in LOCKED for either of these cases:
- prev_q = 2^WIDTH-1 and count = 0 with UP.
- prev_q = 0 and count = 2^WIDTH-1 with DOWN.
REQ-023 dir SHALL update only on UP or DOWN classes and SHALL hold on HOLD or JUMP.
REQ-024 err_count SHALL saturate at 2^ERRW-1 and SHALL never wrap.
REQ-025 err and wrap SHALL never assert in SYNC or ACQUIRE, and SHALL not be simultaneous.
REQ-026 All outputs SHALL be registered, with a latency of one edge from classification.

Reset
REQ-027 When reset is high at an edge, the following SHALL be cleared: state to SYNC, prev_q, up_q, run, locked, dir, err, wrap and err_count, all to 0.
REQ-028 Reset mid-operation SHALL discard all history, and the first post-reset sample SHALL not be compared.
REQ-029 Reset SHALL take priority over every other update in the same cycle.

Structure
REQ-030 The state encoding (SYNC, ACQUIRE, LOCKED) and step-class encoding (UP, DOWN, HOLD, JUMP) SHALL reside in the shared package updown_pkg.
REQ-031 Step classification SHALL be a combinational sub-module, step_classifier (inputs prev and count; output class), so that it can be reused by other counter checkers.
REQ-032 The run counter width SHALL be clog2(LOCK_N+1).

Verification
REQ-033 Scenario: reset, then the counter counts up from 0 -> locked rises 3 edges after reset release (SYNC plus 2 steps); wrap pulses once at 15->0; err_count stays 0.
REQ-034 Scenario: locked and counting up, then up drops to 0 -> counting continues down with no err, because up_q aligns expectation; dir goes to 0 on the first down step.
REQ-035 Scenario: locked, then count is forced from 5 to 9 -> err pulses for exactly one cycle, err_count=1, locked drops, and locked rises again after 2 correct steps.
REQ-036 Scenario: locked, then count is held at 7 for 1 cycle -> err pulses once and err_count increments by 1.
REQ-037 Scenario: reset asserted for one edge while locked with err_count=3 -> all outputs are 0 after that edge, and the next sample is not compared.
REQ-038 Scenario: 300 injected jumps, each preceded by a relock -> err_count reads 255 and stays at 255.
